pa_mem_arbiter: RTL and testbench

Parametrised memory-port arbiter that merges `NUM_PORTS` independent requesters onto the single backing-memory port. Typical requesters are instruction fetch, data read and data write. It uses round-robin arbitration and tracks up to `MAX_OUTSTANDING` in-flight transactions in an ID FIFO. In-order memory responses are routed back to the issuing port. It sits between the core's fetch/memory stages and the memory model/bus, and generalises the fixed IF/read/write request structs in `pa_pkg`.

---
 rtl/pa_mem_arbiter_pkg.sv | 31 +++
 rtl/pa_id_fifo.sv | 58 +++++
 rtl/pa_mem_arbiter.sv | 104 ++++++++++
 tb/tb_pa_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pa_mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: request/response
// structs, default sizing and the fixed requester port assignment.
package pa_mem_arbiter_pkg;

  localparam int PHY_ADDR_LEN        = 32;
  localparam int XLEN                = 32;
  localparam int MEM_NUM_PORTS       = 3;
  localparam int MEM_MAX_OUTSTANDING = 4;

  localparam int MEM_PORT_IF  = 0;
  localparam int MEM_PORT_MRD = 1;
  localparam int MEM_PORT_MWR = 2;

  typedef struct packed {
    logic                    valid;
    logic                    we;
    logic [PHY_ADDR_LEN-1:0] addr;
    logic [XLEN-1:0]         wdata;
  } mem_req_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } mem_resp_t;

  // Single-step modulo for values known to be below 2*n.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/pa_id_fifo.sv
// Small FIFO holding the issuing-port index of each in-flight memory request,
// so in-order responses can be steered back to the right requester.
module pa_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pa_mem_arbiter.sv
// Round-robin arbiter merging NUM_PORTS requesters onto one in-order memory
// port; response routing comes from an ID FIFO of issuing-port indices.
module pa_mem_arbiter
  import pa_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = MEM_NUM_PORTS,
  parameter int MAX_OUTSTANDING = MEM_MAX_OUTSTANDING,
  parameter int ADDR_W          = PHY_ADDR_LEN,
  parameter int DATA_W          = XLEN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]              resp_valid,
  output logic [DATA_W-1:0]                 resp_data,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_req_we,
  output logic [ADDR_W-1:0]                 mem_req_addr,
  output logic [DATA_W-1:0]                 mem_req_wdata,
  input  logic                              mem_resp_valid,
  input  logic [DATA_W-1:0]                 mem_resp_data,
  output logic                              err
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] head;
  logic             any_valid;
  logic             fifo_full, fifo_empty;
  logic             fire, pop;
  logic             err_q, err_d;

  // Candidate: first valid port scanning upward from rr_ptr with wrap.
  always_comb begin
    cand      = rr_ptr_q;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'(rr_wrap(32'(rr_ptr_q) + 32'(i), 32'(NUM_PORTS)));
      if (!any_valid && req_valid[idx]) begin
        cand      = idx;
        any_valid = 1'b1;
      end
    end
  end

  // Outputs are gated with rst_n so they drop the instant reset asserts.
  assign mem_req_valid = rst_n && any_valid && !fifo_full;
  assign mem_req_we    = req_we[cand];
  assign mem_req_addr  = req_addr[cand];
  assign mem_req_wdata = req_wdata[cand];
  assign fire          = mem_req_valid && mem_req_ready;
  assign pop           = rst_n && mem_resp_valid && !fifo_empty;
  assign resp_data     = mem_resp_data;
  assign err           = err_q;

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p]  = fire && (cand == IDX_W'(p));
      resp_valid[p] = pop && (head == IDX_W'(p));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    if (fire) rr_ptr_d = IDX_W'(rr_wrap(32'(cand) + 32'd1, 32'(NUM_PORTS)));
    if (mem_resp_valid && fifo_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  pa_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (cand),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule

// File: tb/tb_pa_mem_arbiter.sv
// Directed bench for pa_mem_arbiter: a cycle-by-cycle vector table for
// contention and FIFO-full behaviour, plus hand sequences for the corner cases.
module tb_pa_mem_arbiter;

  logic             clk;
  logic             rst_n;
  logic [2:0]       req_valid, req_ready, req_we, resp_valid;
  logic [2:0][31:0] req_addr, req_wdata;
  logic [31:0]      resp_data;
  logic             mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]      mem_req_addr, mem_req_wdata;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_data;
  logic             err;

  int nvec = 0;
  int nmis = 0;

  pa_mem_arbiter #(
    .NUM_PORTS       (3),
    .MAX_OUTSTANDING (2),
    .ADDR_W          (32),
    .DATA_W          (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rv;
    logic        mrdy;
    logic        rsp;
    logic [2:0]  exp_ready;
    logic        exp_mvalid;
    logic [2:0]  exp_resp;
    logic [31:0] exp_addr;
    logic        exp_we;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    // Ports: 0 = fetch, 1 = data read, 2 = data write.
    tbl[0]  = '{3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 3'b000, 32'h1000, 1'b0};
    tbl[1]  = '{3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 3'b001, 32'h2000, 1'b0};
    tbl[2]  = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 3'b010, 32'h3000, 1'b1};
    tbl[3]  = '{3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 3'b100, 32'h1000, 1'b0};
    tbl[4]  = '{3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 3'b001, 32'h2000, 1'b0};
    tbl[5]  = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 3'b010, 32'h3000, 1'b1};
    tbl[6]  = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 3'b100, 32'h0,    1'b0};
    tbl[7]  = '{3'b010, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 32'h2000, 1'b0};
    tbl[8]  = '{3'b110, 1'b1, 1'b0, 3'b010, 1'b1, 3'b000, 32'h2000, 1'b0};
    tbl[9]  = '{3'b001, 1'b1, 1'b0, 3'b001, 1'b1, 3'b000, 32'h1000, 1'b0};
    tbl[10] = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0,    1'b0};
    tbl[11] = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b0, 3'b010, 32'h0,    1'b0};
    tbl[12] = '{3'b111, 1'b1, 1'b0, 3'b010, 1'b1, 3'b000, 32'h2000, 1'b0};
    tbl[13] = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 3'b001, 32'h0,    1'b0};
    tbl[14] = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 3'b010, 32'h0,    1'b0};

    rst_n          = 1'b0;
    req_valid      = 3'b000;
    req_we         = 3'b100;
    req_addr[0]    = 32'h1000;
    req_addr[1]    = 32'h2000;
    req_addr[2]    = 32'h3000;
    req_wdata[0]   = 32'hA0;
    req_wdata[1]   = 32'hA1;
    req_wdata[2]   = 32'hA2;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;

    // Reset state with all inputs active.
    #3;
    req_valid      = 3'b111;
    mem_resp_valid = 1'b1;
    #1;
    chk("rst_mvalid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_ready",  {29'b0, req_ready},     32'd0);
    chk("rst_resp",   {29'b0, resp_valid},    32'd0);
    chk("rst_err",    {31'b0, err},           32'd0);
    @(negedge clk);
    req_valid      = 3'b000;
    mem_resp_valid = 1'b0;
    rst_n          = 1'b1;

    // Single read from port 0, response three cycles later.
    @(negedge clk);
    req_valid = 3'b001;
    #1;
    chk("rd_ready",  {29'b0, req_ready},     32'h1);
    chk("rd_mvalid", {31'b0, mem_req_valid}, 32'h1);
    chk("rd_addr",   mem_req_addr,           32'h1000);
    chk("rd_we",     {31'b0, mem_req_we},    32'h0);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("rd_wait1", {29'b0, resp_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("rd_wait2", {29'b0, resp_valid}, 32'h0);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEADBEEF;
    #1;
    chk("rd_resp",  {29'b0, resp_valid}, 32'h1);
    chk("rd_data",  resp_data,           32'hDEADBEEF);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("rd_after", {29'b0, resp_valid}, 32'h0);
    chk("rd_err",   {31'b0, err},        32'h0);

    // Write from port 2.
    req_addr[2]  = 32'h2000;
    req_wdata[2] = 32'h55AA;
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    chk("wr_ready", {29'b0, req_ready},  32'h4);
    chk("wr_we",    {31'b0, mem_req_we}, 32'h1);
    chk("wr_wdata", mem_req_wdata,       32'h55AA);
    chk("wr_addr",  mem_req_addr,        32'h2000);
    @(negedge clk);
    req_valid      = 3'b000;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0;
    #1;
    chk("wr_ack", {29'b0, resp_valid}, 32'h4);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    req_addr[2]    = 32'h3000;
    req_wdata[2]   = 32'hA2;

    // Contention, held requests and FIFO-full table.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req_valid      = tbl[i].rv;
      mem_req_ready  = tbl[i].mrdy;
      mem_resp_valid = tbl[i].rsp;
      mem_resp_data  = 32'hC0DE0000 + 32'(i);
      #1;
      chk($sformatf("v%0d_ready", i),  {29'b0, req_ready},     {29'b0, tbl[i].exp_ready});
      chk($sformatf("v%0d_mvalid", i), {31'b0, mem_req_valid}, {31'b0, tbl[i].exp_mvalid});
      chk($sformatf("v%0d_resp", i),   {29'b0, resp_valid},    {29'b0, tbl[i].exp_resp});
      if (tbl[i].exp_mvalid) begin
        chk($sformatf("v%0d_addr", i), mem_req_addr,        tbl[i].exp_addr);
        chk($sformatf("v%0d_we", i),   {31'b0, mem_req_we}, {31'b0, tbl[i].exp_we});
      end
      if (tbl[i].exp_resp != 3'b000)
        chk($sformatf("v%0d_data", i), resp_data, 32'hC0DE0000 + 32'(i));
    end

    // Spurious response with the FIFO empty.
    @(negedge clk);
    req_valid      = 3'b000;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    #1;
    chk("sp_resp",  {29'b0, resp_valid}, 32'h0);
    chk("sp_err0",  {31'b0, err},        32'h0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("sp_err1", {31'b0, err}, 32'h1);
    repeat (3) @(negedge clk);
    #1;
    chk("sp_sticky", {31'b0, err}, 32'h1);

    // Reset with two requests outstanding (pointer sits at 2 here).
    @(negedge clk);
    req_valid = 3'b011;
    #1;
    chk("mf_grant0", {29'b0, req_ready}, 32'h1);
    @(negedge clk);
    #1;
    chk("mf_grant1", {29'b0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid      = 3'b111;
    mem_resp_valid = 1'b1;
    #1;
    chk("mf_full",   {31'b0, mem_req_valid}, 32'h0);
    chk("mf_resp",   {29'b0, resp_valid},    32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mf_rst_mvalid", {31'b0, mem_req_valid}, 32'h0);
    chk("mf_rst_ready",  {29'b0, req_ready},     32'h0);
    chk("mf_rst_resp",   {29'b0, resp_valid},    32'h0);
    chk("mf_rst_err",    {31'b0, err},           32'h0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    req_valid      = 3'b000;
    rst_n          = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    #1;
    chk("mf_late_resp", {29'b0, resp_valid}, 32'h0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    req_valid      = 3'b111;
    #1;
    chk("mf_first_grant", {29'b0, req_ready}, 32'h1);
    chk("mf_late_err",    {31'b0, err},       32'h1);
    @(negedge clk);
    req_valid = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
